// File: rtl/fp_sort_pipe_pkg.sv
// Shared definitions for the FP adder operand-ordering stage.
// Holds the default field widths, the compare-mode encodings and helpers that
// locate the sign/exponent/mantissa fields inside a packed operand word
// {sign, exponent, mantissa}.
package fp_add_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 28;

    // Compare-mode encodings
    localparam int CMP_MAN_ONLY = 0;
    localparam int CMP_FULL     = 1;

    function automatic int sign_idx(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

    function automatic int exp_hi(input int exp_w, input int man_w);
        return exp_w + man_w - 1;
    endfunction

    function automatic int exp_lo(input int man_w);
        return man_w;
    endfunction

    function automatic int man_hi(input int man_w);
        return man_w - 1;
    endfunction

endpackage

// File: rtl/fp_mag_cmp.sv
// Combinational unsigned magnitude comparator.
// Ports:
//   key_a, key_b : compare keys (KEY_W bits, unsigned)
//   ge           : key_a >= key_b
//   eq           : key_a == key_b
module fp_mag_cmp #(
    parameter int KEY_W = 28
) (
    input  logic [KEY_W-1:0] key_a,
    input  logic [KEY_W-1:0] key_b,
    output logic             ge,
    output logic             eq
);

    assign ge = (key_a >= key_b);
    assign eq = (key_a == key_b);

endmodule

// File: rtl/fp_sort_pipe.sv
// Two-stage elastic operand-ordering stage for the FP adder.
// S1 captures the operand fields, the effective B sign, the magnitude compare
// result and the eq/effective-subtract flags; S2 registers the swapped
// larger/smaller outputs. Back-pressure from out_ready propagates to in_ready.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake for NA, NB, op
//   NA, NB              : packed operands {sign, exponent, mantissa}
//   op                  : 0 = A+B, 1 = A-B
//   out_valid/out_ready : output handshake
//   Comp                : 1 when |A| >= |B| (no swap)
//   SL, SS              : effective signs of larger / smaller operand
//   EO                  : result exponent
//   ML, MS              : mantissas of larger / smaller operand
//   eff_sub, eq_mag     : effective subtraction, exact magnitude tie
module fp_sort_pipe
    import fp_add_pkg::*;
#(
    parameter  int EXP_W    = EXP_W_DEF,
    parameter  int MAN_W    = MAN_W_DEF,
    parameter  int CMP_MODE = CMP_MAN_ONLY,
    localparam int W        = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     NA,
    input  logic [W-1:0]     NB,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Comp,
    output logic             SL,
    output logic             SS,
    output logic [EXP_W-1:0] EO,
    output logic [MAN_W-1:0] ML,
    output logic [MAN_W-1:0] MS,
    output logic             eff_sub,
    output logic             eq_mag
);

    localparam int S_IDX = sign_idx(EXP_W, MAN_W);
    localparam int E_HI  = exp_hi(EXP_W, MAN_W);
    localparam int E_LO  = exp_lo(MAN_W);
    localparam int M_HI  = man_hi(MAN_W);
    localparam int KEY_W = (CMP_MODE == CMP_FULL) ? EXP_W + MAN_W : MAN_W;

    // ---------------- field extraction and compare ----------------
    logic             sa, sb_eff;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic [KEY_W-1:0] key_a, key_b;
    logic             key_ge, key_eq;

    assign sa     = NA[S_IDX];
    assign sb_eff = NB[S_IDX] ^ op;
    assign exp_a  = NA[E_HI:E_LO];
    assign exp_b  = NB[E_HI:E_LO];
    assign man_a  = NA[M_HI:0];
    assign man_b  = NB[M_HI:0];

    if (CMP_MODE == CMP_FULL) begin : g_key_full
        assign key_a = {exp_a, man_a};
        assign key_b = {exp_b, man_b};
    end else begin : g_key_man
        assign key_a = man_a;
        assign key_b = man_b;
    end

    fp_mag_cmp #(
        .KEY_W (KEY_W)
    ) u_cmp (
        .key_a (key_a),
        .key_b (key_b),
        .ge    (key_ge),
        .eq    (key_eq)
    );

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_load, in_fire;

    always_comb begin
        s2_load     = s1_valid_q && (!out_valid_q || out_ready);
        in_ready    = !s1_valid_q || s2_load;
        in_fire     = in_valid && in_ready;
        // S1 stays full when it is refilled in the same cycle it advances
        s1_valid_d  = in_fire || (s1_valid_q && !s2_load);
        out_valid_d = s2_load || (out_valid_q && !out_ready);
    end

    // ---------------- stage 1 registers ----------------
    logic             s1_sa_q, s1_sb_q, s1_comp_q, s1_eq_q, s1_sub_q;
    logic [EXP_W-1:0] s1_expa_q, s1_expb_q;
    logic [MAN_W-1:0] s1_mana_q, s1_manb_q;

    // ---------------- stage 2 next values (swap) ----------------
    logic             sl_d, ss_d;
    logic [EXP_W-1:0] eo_d;
    logic [MAN_W-1:0] ml_d, ms_d;

    always_comb begin
        sl_d = s1_comp_q ? s1_sa_q   : s1_sb_q;
        ss_d = s1_comp_q ? s1_sb_q   : s1_sa_q;
        ml_d = s1_comp_q ? s1_mana_q : s1_manb_q;
        ms_d = s1_comp_q ? s1_manb_q : s1_mana_q;
        // Pre-aligned operands share an exponent, so A's is always the result
        eo_d = (CMP_MODE == CMP_MAN_ONLY || s1_comp_q) ? s1_expa_q : s1_expb_q;
    end

    logic             comp_q, sl_q, ss_q, sub_q, eq_q;
    logic [EXP_W-1:0] eo_q;
    logic [MAN_W-1:0] ml_q, ms_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_sa_q     <= 1'b0;
            s1_sb_q     <= 1'b0;
            s1_comp_q   <= 1'b0;
            s1_eq_q     <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_expa_q   <= '0;
            s1_expb_q   <= '0;
            s1_mana_q   <= '0;
            s1_manb_q   <= '0;
            comp_q      <= 1'b0;
            sl_q        <= 1'b0;
            ss_q        <= 1'b0;
            sub_q       <= 1'b0;
            eq_q        <= 1'b0;
            eo_q        <= '0;
            ml_q        <= '0;
            ms_q        <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_fire) begin
                s1_sa_q   <= sa;
                s1_sb_q   <= sb_eff;
                s1_comp_q <= key_ge;
                s1_eq_q   <= key_eq;
                s1_sub_q  <= sa ^ sb_eff;
                s1_expa_q <= exp_a;
                s1_expb_q <= exp_b;
                s1_mana_q <= man_a;
                s1_manb_q <= man_b;
            end
            if (s2_load) begin
                comp_q <= s1_comp_q;
                sl_q   <= sl_d;
                ss_q   <= ss_d;
                sub_q  <= s1_sub_q;
                eq_q   <= s1_eq_q;
                eo_q   <= eo_d;
                ml_q   <= ml_d;
                ms_q   <= ms_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Comp      = comp_q;
    assign SL        = sl_q;
    assign SS        = ss_q;
    assign EO        = eo_q;
    assign ML        = ml_q;
    assign MS        = ms_q;
    assign eff_sub   = sub_q;
    assign eq_mag    = eq_q;

endmodule

// File: tb/tb_fp_sort_pipe.sv
// Testbench for fp_sort_pipe: three instances run in lockstep on shared
// handshake signals (8/28 pre-aligned, 11/55 full compare, 8/28 full compare),
// checked every cycle against a queue-based reference model.
module tb_fp_sort_pipe;

    typedef struct packed {
        logic        comp;
        logic        sl;
        logic        ss;
        logic [63:0] eo;
        logic [63:0] ml;
        logic [63:0] ms;
        logic        eff_sub;
        logic        eq;
    } res_t;

    typedef struct {
        res_t [2:0] r;
        int         acc;
    } item_t;

    localparam int EW [3] = '{8, 11, 8};
    localparam int MW [3] = '{28, 55, 28};
    localparam int MD [3] = '{0, 1, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic op = 1'b0;
    logic [127:0] na [3];
    logic [127:0] nb [3];

    logic [36:0] na0, nb0, na2, nb2;
    logic [66:0] na1, nb1;
    logic ir0, ir1, ir2, ov0, ov1, ov2;
    logic c0, c1, c2, sl0, sl1, sl2, ss0, ss1, ss2;
    logic sub0, sub1, sub2, eq0, eq1, eq2;
    logic [7:0]  eo0, eo2;
    logic [10:0] eo1;
    logic [27:0] ml0, ms0, ml2, ms2;
    logic [54:0] ml1, ms1;

    assign na0 = na[0][36:0];
    assign nb0 = nb[0][36:0];
    assign na1 = na[1][66:0];
    assign nb1 = nb[1][66:0];
    assign na2 = na[2][36:0];
    assign nb2 = nb[2][36:0];

    always #5 clk = ~clk;

    fp_sort_pipe #(.EXP_W(8), .MAN_W(28), .CMP_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .NA(na0), .NB(nb0),
        .op(op), .out_valid(ov0), .out_ready(out_ready), .Comp(c0), .SL(sl0), .SS(ss0),
        .EO(eo0), .ML(ml0), .MS(ms0), .eff_sub(sub0), .eq_mag(eq0));

    fp_sort_pipe #(.EXP_W(11), .MAN_W(55), .CMP_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .NA(na1), .NB(nb1),
        .op(op), .out_valid(ov1), .out_ready(out_ready), .Comp(c1), .SL(sl1), .SS(ss1),
        .EO(eo1), .ML(ml1), .MS(ms1), .eff_sub(sub1), .eq_mag(eq1));

    fp_sort_pipe #(.EXP_W(8), .MAN_W(28), .CMP_MODE(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .NA(na2), .NB(nb2),
        .op(op), .out_valid(ov2), .out_ready(out_ready), .Comp(c2), .SL(sl2), .SS(ss2),
        .EO(eo2), .ML(ml2), .MS(ms2), .eff_sub(sub2), .eq_mag(eq2));

    res_t act [3];
    logic ov [3];
    logic ir [3];

    always_comb begin
        act[0] = {c0, sl0, ss0, 64'(eo0), 64'(ml0), 64'(ms0), sub0, eq0};
        act[1] = {c1, sl1, ss1, 64'(eo1), 64'(ml1), 64'(ms1), sub1, eq1};
        act[2] = {c2, sl2, ss2, 64'(eo2), 64'(ml2), 64'(ms2), sub2, eq2};
        ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
        ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
    end

    int    n_chk = 0;
    int    n_err = 0;
    int    edge_n = 0;
    item_t pipe_q[$];
    bit    prev_stall = 1'b0;
    res_t  prev_act [3];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // Reference: ordering rules computed directly from the field values
    function automatic res_t model(input int ew, input int mw, input int md,
                                   input logic [127:0] a, input logic [127:0] b,
                                   input logic o);
        res_t         r;
        logic [127:0] t;
        logic [63:0]  ma, mb, ea, eb;
        logic         sa, sb;
        bit           a_big, tie;
        ma = a[63:0] & mk(mw);
        mb = b[63:0] & mk(mw);
        t  = a >> mw;  ea = t[63:0] & mk(ew);
        t  = b >> mw;  eb = t[63:0] & mk(ew);
        sa = a[ew+mw];
        sb = b[ew+mw] ^ o;
        if (md == 0) begin
            a_big = (ma >= mb);
            tie   = (ma == mb);
        end else begin
            a_big = (ea > eb) || (ea == eb && ma >= mb);
            tie   = (ea == eb) && (ma == mb);
        end
        r.comp    = a_big;
        r.sl      = a_big ? sa : sb;
        r.ss      = a_big ? sb : sa;
        r.ml      = a_big ? ma : mb;
        r.ms      = a_big ? mb : ma;
        r.eo      = (md == 0) ? ea : (a_big ? ea : eb);
        r.eff_sub = sa ^ sb;
        r.eq      = tie;
        return r;
    endfunction

    // One clock cycle; entered and left at a falling edge.
    task automatic step(input logic v, input logic o, input logic r, output bit fired);
        bit exp_ov, exp_ir, drain;
        exp_ov = (pipe_q.size() > 0) && (pipe_q[0].acc < edge_n);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out_valid[%0d]", i), 256'(ov[i]), 256'(exp_ov));
            if (exp_ov)
                chk($sformatf("data[%0d]", i), 256'(act[i]), 256'(pipe_q[0].r[i]));
            if (prev_stall)
                chk($sformatf("hold[%0d]", i), 256'(act[i]), 256'(prev_act[i]));
        end
        in_valid  = v;
        op        = o;
        out_ready = r;
        #1;
        exp_ir = !(pipe_q.size() == 2 && !r);
        for (int i = 0; i < 3; i++)
            chk($sformatf("in_ready[%0d]", i), 256'(ir[i]), 256'(exp_ir));
        fired      = v && exp_ir;
        drain      = exp_ov && r;
        prev_stall = exp_ov && !r;
        for (int i = 0; i < 3; i++) prev_act[i] = act[i];
        @(posedge clk);
        edge_n++;
        if (drain) void'(pipe_q.pop_front());
        if (fired) begin
            item_t it;
            for (int i = 0; i < 3; i++)
                it.r[i] = model(EW[i], MW[i], MD[i], na[i], nb[i], o);
            it.acc = edge_n;
            pipe_q.push_back(it);
        end
        @(negedge clk);
    endtask

    task automatic rand_operands();
        int sel;
        for (int i = 0; i < 3; i++) begin
            na[i] = {$urandom, $urandom, $urandom, $urandom};
            nb[i] = {$urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel == 0) nb[i] = na[i];
            else if (sel == 1) nb[i] = (nb[i] & ~{64'h0, mk(MW[i])}) | (na[i] & {64'h0, mk(MW[i])});
        end
    endtask

    task automatic drain_all();
        bit f;
        for (int k = 0; k < 20 && pipe_q.size() > 0; k++) step(1'b0, 1'b0, 1'b1, f);
        chk("drain_empty", 256'(pipe_q.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit   f;
        int   k, cyc;
        res_t lit;
        for (int i = 0; i < 3; i++) begin na[i] = '0; nb[i] = '0; end

        // Model pinned to hand-computed results
        lit = '{comp:1'b0, sl:1'b1, ss:1'b0, eo:64'h80, ml:64'h20, ms:64'h10, eff_sub:1'b1, eq:1'b0};
        chk("model_swap", 256'(model(8, 28, 0, {1'b0, 8'h80, 28'h10}, {1'b1, 8'h80, 28'h20}, 1'b0)), 256'(lit));
        lit = '{comp:1'b1, sl:1'b0, ss:1'b0, eo:64'h81, ml:64'h1, ms:64'hFFFFFFF, eff_sub:1'b0, eq:1'b0};
        chk("model_full", 256'(model(8, 28, 1, {1'b0, 8'h81, 28'h1}, {1'b0, 8'h80, 28'hFFFFFFF}, 1'b0)), 256'(lit));

        // Reset state
        #3;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ov[%0d]", i), 256'(ov[i]), 256'(0));
            chk($sformatf("rst_data[%0d]", i), 256'(act[i]), 256'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 256'(ir[0]), 256'(1));

        // Directed: swap (pre-aligned), full compare, then tie with subtract
        na[0] = {1'b0, 8'h80, 28'h0000010};
        nb[0] = {1'b1, 8'h80, 28'h0000020};
        na[1] = {1'b0, 11'h401, 55'h1};
        nb[1] = {1'b1, 11'h400, 55'h7F_FFFF_FFFF_FFFF};
        na[2] = {1'b0, 8'h81, 28'h0000001};
        nb[2] = {1'b0, 8'h80, 28'hFFFFFFF};
        step(1'b1, 1'b0, 1'b1, f);
        na[0] = {1'b0, 8'h7F, 28'h1234567};
        nb[0] = na[0];
        na[1] = {1'b1, 11'h3FF, 55'h12_3456_789A_BCDE};
        nb[1] = na[1];
        na[2] = {1'b1, 8'h10, 28'h0ABCDEF};
        nb[2] = na[2];
        step(1'b1, 1'b1, 1'b1, f);
        lit = '{comp:1'b0, sl:1'b1, ss:1'b0, eo:64'h80, ml:64'h20, ms:64'h10, eff_sub:1'b1, eq:1'b0};
        chk("lit_swap", 256'(act[0]), 256'(lit));
        lit = '{comp:1'b1, sl:1'b0, ss:1'b1, eo:64'h401, ml:64'h1, ms:64'h7F_FFFF_FFFF_FFFF, eff_sub:1'b1, eq:1'b0};
        chk("lit_full_wide", 256'(act[1]), 256'(lit));
        lit = '{comp:1'b1, sl:1'b0, ss:1'b0, eo:64'h81, ml:64'h1, ms:64'hFFFFFFF, eff_sub:1'b0, eq:1'b0};
        chk("lit_full", 256'(act[2]), 256'(lit));
        step(1'b0, 1'b0, 1'b1, f);
        lit = '{comp:1'b1, sl:1'b0, ss:1'b1, eo:64'h7F, ml:64'h1234567, ms:64'h1234567, eff_sub:1'b1, eq:1'b1};
        chk("lit_tie", 256'(act[0]), 256'(lit));
        chk("lit_tie_wide_eq", 256'({c1, eq1, sub1, sl1, ss1}), 256'(5'b11110));
        drain_all();

        // Back-pressure: 6 items, out_ready low for 5 cycles
        k = 0;
        cyc = 0;
        rand_operands();
        while (k < 6 && cyc < 40) begin
            if (cyc == 3) begin
                chk("bp_in_ready_low", 256'(ir[0]), 256'(0));
                chk("bp_out_valid", 256'(ov[0]), 256'(1));
            end
            step(1'b1, 1'b0, (cyc >= 5), f);
            if (f) begin
                k++;
                rand_operands();
            end
            cyc++;
        end
        chk("bp_accepted", 256'(k), 256'(6));
        drain_all();

        // Randomized traffic
        for (int n = 0; n < 1000; n++) begin
            rand_operands();
            step(($urandom_range(0, 9) < 7), $urandom_range(0, 1), ($urandom_range(0, 9) < 7), f);
        end
        drain_all();

        // Reset with both stages full
        rand_operands();
        step(1'b1, 1'b0, 1'b0, f);
        rand_operands();
        step(1'b1, 1'b1, 1'b0, f);
        chk("pre_rst_full", 256'(ir[0]), 256'(0));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush_ov[%0d]", i), 256'(ov[i]), 256'(0));
            chk($sformatf("flush_data[%0d]", i), 256'(act[i]), 256'(0));
        end
        #1 rst = 1'b0;
        pipe_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 256'(ir[0]), 256'(1));
        chk("post_rst_ov", 256'(ov[0]), 256'(0));
        for (int n = 0; n < 50; n++) begin
            rand_operands();
            step(($urandom_range(0, 1) == 1), $urandom_range(0, 1), 1'b1, f);
        end
        drain_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
